// File: rtl/div_ctrl.sv
// div_ctrl: handshake controller around an external 4-step restoring divider.
// Accepts a dividend/divisor pair, loads the divider, waits out its four steps,
// captures quotient and remainder, and presents them until the consumer takes them.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (in_a dividend, in_b divisor)
//   out_valid/out_ready   result handshake (out_q quotient, out_r remainder, out_err div-by-zero)
//   div_ld                one-cycle load strobe to the divider
//   div_a, div_b          registered operands held for the divider
//   div_y                 quotient returned by the divider
//
// Build option: define DIV_ZERO_CHK_EN to short-circuit a zero divisor straight
// to the result stage with out_err set; otherwise out_err is tied low.
module div_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_q,
    output logic [3:0] out_r,
    output logic       out_err,
    output logic       div_ld,
    output logic [3:0] div_a,
    output logic [3:0] div_b,
    input  logic [3:0] div_y
);

    localparam int unsigned W = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_CAPT = 3'd3,
        S_OUT  = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     step_q, step_d;
    logic [W-1:0]   div_a_q, div_a_d;
    logic [W-1:0]   div_b_q, div_b_d;
    logic [W-1:0]   out_q_q, out_q_d;
    logic [W-1:0]   out_r_q, out_r_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           div_ld_q, div_ld_d;
    logic           out_err_d;
    logic           accept_c;

    assign accept_c = in_valid & in_ready_q;

    // Next-state and next-output logic; handshake outputs follow the next state.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        div_a_d   = div_a_q;
        div_b_d   = div_b_q;
        out_q_d   = out_q_q;
        out_r_d   = out_r_q;
        out_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    div_a_d = in_a;
                    div_b_d = in_b;
                    state_d = S_LOAD;
`ifdef DIV_ZERO_CHK_EN
                    if (in_b == W'(0)) begin
                        state_d   = S_OUT;
                        out_q_d   = {W{1'b1}};
                        out_r_d   = in_a;
                        out_err_d = 1'b1;
                    end
`endif
                end
            end
            S_LOAD: begin
                state_d = S_CALC;
                step_d  = 2'd0;
            end
            S_CALC: begin
                step_d = 2'(step_q + 2'd1);
                if (step_q == 2'd3) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                out_q_d = div_y;
                // Remainder reconstructed from the quotient, truncated to operand width.
                out_r_d = W'(div_a_q - W'(div_y * div_b_q));
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_OUT);
        div_ld_d    = (state_d == S_LOAD);
    end

`ifdef DIV_ZERO_CHK_EN
    logic out_err_q;

    // Error flag changes only when a new result is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_err_q <= 1'b0;
        end else if ((state_q == S_CAPT) || (state_q == S_IDLE && accept_c)) begin
            out_err_q <= out_err_d;
        end
    end

    assign out_err = out_err_q;
`else
    logic unused_err;
    assign unused_err = out_err_d;
    assign out_err    = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= 2'd0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            out_q_q     <= '0;
            out_r_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            div_ld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            out_q_q     <= out_q_d;
            out_r_q     <= out_r_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            div_ld_q    <= div_ld_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign div_ld    = div_ld_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign out_q     = out_q_q;
    assign out_r     = out_r_q;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair on in_a/in_b is offered.
REQ-005 in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 in_a  input  4  dividend.
REQ-007 in_b  input  4  divisor.
REQ-008 out_valid  output  1  result on out_q/out_r/out_err is valid.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_q  output  4  quotient.
REQ-011 out_r  output  4  remainder.
REQ-012 out_err  output  1  divide-by-zero flag.
REQ-013 div_ld  output  1  load strobe to the downstream 4-step restoring divider.
REQ-014 div_a  output  4  registered dividend driven to the divider.
REQ-015 div_b  output  4  registered divisor driven to the divider.
REQ-016 div_y  input  4  quotient returned by the divider.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, CALC, CAPT and OUT.
REQ-018 in_ready SHALL be 1 only in IDLE; a transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-019 On transfer, in_a/in_b SHALL be latched into div_a/div_b, and the FSM SHALL go to LOAD.
REQ-020 LOAD SHALL last exactly one cycle with div_ld=1; div_ld SHALL be 0 in all other states.
REQ-021 CALC SHALL last exactly 4 cycles, counted by a 2-bit step counter cleared on entry.
REQ-022 CAPT SHALL last one cycle; at its ending edge, out_q SHALL take div_y and out_r SHALL take (div_a - div_y*div_b) truncated to 4 bits; the FSM then goes to OUT.
REQ-023 Accept-to-out_valid latency SHALL be 7 cycles: accept edge, then LOAD 1, CALC 4, CAPT 1.
REQ-024 In OUT, out_valid SHALL be 1 and out_q/out_r/out_err SHALL stay stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-025 out_valid SHALL be 0 in all states other than OUT.
REQ-026 No new operand SHALL be accepted in the cycle a result is consumed; in_ready rises the following cycle.
REQ-027 div_a/div_b SHALL remain constant from accept until return to IDLE.
REQ-028 in_valid while not in IDLE SHALL be ignored, and the operands SHALL not be latched.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE from any state, including mid-CALC, and SHALL take precedence over every other event.
REQ-030 After reset: div_ld=0, out_valid=0, in_ready=1, out_q=0, out_r=0, out_err=0, div_a=0, div_b=0, step counter=0.
REQ-031 An operation interrupted by reset SHALL produce no result.

Configuration
REQ-032 With macro DIV_ZERO_CHK_EN defined: a transfer with in_b=0 SHALL bypass LOAD/CALC/CAPT and go directly to OUT, with out_q=4'hF, out_r=in_a, out_err=1; out_valid SHALL be asserted the cycle after the accept, and div_ld SHALL stay 0.
REQ-033 Without DIV_ZERO_CHK_EN: out_err SHALL be tied to 0, and in_b=0 SHALL follow the normal 7-cycle path, yielding out_q=4'hF and out_r=in_a from the divider.

Verification
REQ-034 a=13, b=4, out_ready=1 -> out_valid 7 cycles after accept, q=3, r=1, err=0, div_ld high exactly 1 cycle.
REQ-035 a=15, b=1, then a=3, b=7 back to back -> q=15, r=0, then q=0, r=3; in_ready=0 throughout the first operation.
REQ-036 a=9, b=5 with out_ready held 0 for 5 cycles -> q=1, r=4 held stable with out_valid=1, released on the first out_ready=1 edge.
REQ-037 a=9, b=0 -> with DIV_ZERO_CHK_EN: q=F, r=9, err=1 at 1-cycle latency; without it: q=F, r=9, err=0 at 7-cycle latency.
REQ-038 rst pulsed in the 2nd CALC cycle of a=12, b=3 -> next cycle IDLE, all outputs at reset values, no out_valid; a following a=12, b=3 -> q=4, r=0.
REQ-039 in_valid=1 during CALC with different operands -> div_a/div_b unchanged, result matches the first operand pair.
